// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer: 2-FF synchroniser, shared-tick hold counter and press/release pulses.
// Optional auto-repeat on held buttons is enabled by defining DEBOUNCE_REPEAT_EN.
module button_debounce_multi #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 4,
    parameter int HOLD         = 15,
    parameter int RPT_W        = 6,
    parameter int REPEAT_DELAY = 40,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                countdown_en,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HOLDOFF  = 2'd2
    } ch_state_t;

    localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD);

    // Elaboration-time parameter range checks.
    if (CHANNELS < 1 || HOLD < 1 || HOLD > (2**CNT_W) - 1) begin : g_bad_hold
        $error("button_debounce_multi: CHANNELS/HOLD out of range");
    end
    if (REPEAT_DELAY < 1 || REPEAT_DELAY > (2**RPT_W) - 1 ||
        REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
        $error("button_debounce_multi: repeat parameters out of range");
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             prev_out;
        logic             rpt_fire;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        ch_state_t        state;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                cnt      <= '0;
                prev_out <= 1'b0;
            end else begin
                s1       <= button_in[ch];
                s2       <= s1;
                cnt      <= cnt_next;
                prev_out <= button_out[ch];
            end
        end

        // The channel state is a pure decode of s2 and the hold counter.
        always_comb begin
            state = ST_IDLE;
            if (s2) begin
                state = ST_PRESSED;
            end else if (cnt != '0) begin
                state = ST_HOLDOFF;
            end
        end

        always_comb begin
            cnt_next = cnt;
            case (state)
                ST_PRESSED: cnt_next = HOLD_V;
                ST_HOLDOFF: if (countdown_en) cnt_next = cnt - CNT_W'(1);
                default:    cnt_next = cnt;
            endcase
        end

`ifdef DEBOUNCE_REPEAT_EN
        localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

        logic [RPT_W-1:0] rpt;
        logic             rpt_pulse;

        // Ticks count only while pressed with the level already asserted.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rpt       <= '0;
                rpt_pulse <= 1'b0;
            end else begin
                rpt_pulse <= 1'b0;
                if (state != ST_PRESSED || !button_out[ch]) begin
                    rpt <= '0;
                end else if (countdown_en) begin
                    if (rpt == RPT_LAST) begin
                        rpt       <= RPT_RELOAD;
                        rpt_pulse <= 1'b1;
                    end else begin
                        rpt <= rpt + RPT_W'(1);
                    end
                end
            end
        end

        assign rpt_fire = rpt_pulse;
`else
        assign rpt_fire = 1'b0;
`endif

        assign button_out[ch]    = (cnt != '0);
        assign press_pulse[ch]   = (button_out[ch] & ~prev_out) | rpt_fire;
        assign release_pulse[ch] = ~button_out[ch] & prev_out;
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed self-checking bench for button_debounce_multi (CHANNELS=4, HOLD=15, repeat 40/10).
module tb_button_debounce_multi;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       countdown_en;
    logic [3:0] button_in;
    logic [3:0] button_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int EXP_PRESSES = 5;
`else
    localparam int EXP_PRESSES = 1;
`endif

    button_debounce_multi #(
        .CHANNELS(4), .CNT_W(4), .HOLD(15),
        .RPT_W(6), .REPEAT_DELAY(40), .REPEAT_RATE(10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .countdown_en (countdown_en),
        .button_in    (button_in),
        .button_out   (button_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int press_cnt[4] = '{default: 0};
    int rel_cnt[4]   = '{default: 0};
    int overlap      = 0;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i]) press_cnt[i] = press_cnt[i] + 1;
            if (release_pulse[i]) rel_cnt[i] = rel_cnt[i] + 1;
            if (press_pulse[i] && release_pulse[i]) overlap = overlap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            countdown_en = 1'b1;
            step(1);
            countdown_en = 1'b0;
            step(1);
        end
    endtask

    int p0, r0, p2, r2, p3, r3;

    initial begin
        reset_n      = 1'b0;
        countdown_en = 1'b0;
        button_in    = 4'hF;

        // Reset held with all buttons pressed
        step(3);
        check("rst_out", button_out, 4'h0);
        check("rst_press", press_pulse, 4'h0);
        check("rst_release", release_pulse, 4'h0);
        reset_n = 1'b1;
        step(2);
        check("press_lat_early", button_out, 4'h0);
        step(1);
        check("press_lat_out", button_out, 4'hF);
        check("press_lat_pulse", press_pulse, 4'hF);
        step(1);
        check("press_pulse_1cyc", press_pulse, 4'h0);
        check("press_hold_out", button_out, 4'hF);

        // Release all, 14 ticks keep level, 15th drops it
        button_in = 4'h0;
        step(2);
        tick_n(14);
        check("tick14_out", button_out, 4'hF);
        check("tick14_release", release_pulse, 4'h0);
        countdown_en = 1'b1;
        step(1);
        countdown_en = 1'b0;
        check("tick15_out", button_out, 4'h0);
        check("tick15_release", release_pulse, 4'hF);
        step(1);
        check("release_1cyc", release_pulse, 4'h0);

        // Ch1 bounces during holdoff at cnt=7
        p0 = press_cnt[1];
        r0 = rel_cnt[1];
        button_in = 4'b0010;
        step(3);
        check("ch1_press", button_out, 4'b0010);
        button_in = 4'b0000;
        step(2);
        tick_n(8);
        for (int i = 0; i < 4; i++) begin
            button_in = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            step(2);
        end
        check("ch1_bounce_out", button_out, 4'b0010);
        tick_n(14);
        check("ch1_reload_out", button_out, 4'b0010);
        countdown_en = 1'b1;
        step(1);
        countdown_en = 1'b0;
        check("ch1_fall_out", button_out, 4'b0000);
        check("ch1_fall_release", release_pulse, 4'b0010);
        step(2);
        check("ch1_press_count", press_cnt[1] - p0, 1);
        check("ch1_release_count", rel_cnt[1] - r0, 1);

        // Ch2 with countdown_en tied high; ch3 untouched
        p2 = press_cnt[2]; r2 = rel_cnt[2];
        p3 = press_cnt[3]; r3 = rel_cnt[3];
        countdown_en = 1'b1;
        button_in = 4'b0100;
        step(3);
        check("ch2_press_out", button_out, 4'b0100);
        check("ch2_press_pulse", press_pulse, 4'b0100);
        step(4);
        check("ch2_hold_out", button_out, 4'b0100);
        button_in = 4'b0000;
        step(16);
        check("ch2_before_fall", button_out, 4'b0100);
        step(1);
        check("ch2_fall_out", button_out, 4'b0000);
        check("ch2_fall_release", release_pulse, 4'b0100);
        countdown_en = 1'b0;
        step(2);
        check("ch2_press_count", press_cnt[2] - p2, 1);
        check("ch2_release_count", rel_cnt[2] - r2, 1);
        check("ch3_press_count", press_cnt[3] - p3, 0);
        check("ch3_release_count", rel_cnt[3] - r3, 0);

        // Reset in the middle of ch0 holdoff (cnt=5)
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        button_in = 4'b0001;
        step(3);
        button_in = 4'b0000;
        step(2);
        tick_n(10);
        check("ch0_holdoff_out", button_out, 4'b0001);
        reset_n = 1'b0;
        #1;
        check("midrst_out", button_out, 4'h0);
        check("midrst_release", release_pulse, 4'h0);
        step(2);
        reset_n = 1'b1;
        step(3);
        check("postrst_out", button_out, 4'h0);
        step(1);
        check("midrst_release_count", rel_cnt[0] - r0, 0);
        check("midrst_press_count", press_cnt[0] - p0, 1);

        // Ch0 held for 70 ticks (auto-repeat when enabled)
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        button_in = 4'b0001;
        step(3);
        check("rpt_press_out", button_out, 4'b0001);
        tick_n(39);
        check("rpt_tick39_count", press_cnt[0] - p0, 1);
        tick_n(31);
        check("rpt_hold_out", button_out, 4'b0001);
        button_in = 4'b0000;
        step(2);
        tick_n(15);
        step(2);
        check("rpt_final_out", button_out, 4'b0000);
        check("rpt_press_count", press_cnt[0] - p0, EXP_PRESSES);
        check("rpt_release_count", rel_cnt[0] - r0, 1);
        check("pulse_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
